// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C bus lines plus parallel byte side of the I2C target
interface i2c_target_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [2:0] state;

  modport slave (
    input  sclk, sda_in, tx_data,
    output sda_out, rx_data, rx_valid, tx_req, busy, state
  );

  modport master (
    output sclk, sda_in, tx_data,
    input  sda_out, rx_data, rx_valid, tx_req, busy, state
  );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - oversampling I2C target: START/STOP detect, address match, byte write/read
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h5A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  i2c_target_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6,
    IGNORE    = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_sclk_hist;
  logic                   r_sda_hist;

  state_t     r_state,     w_state_nxt;
  logic [7:0] r_shift,     w_shift_nxt;
  logic [2:0] r_cnt,       w_cnt_nxt;
  logic       r_byte_done, w_byte_done_nxt;
  logic       r_rw,        w_rw_nxt;
  logic       r_acked,     w_acked_nxt;
  logic       r_sda_out,   w_sda_out_nxt;
  logic [7:0] r_rx_data,   w_rx_data_nxt;
  logic       r_rx_valid,  w_rx_valid_nxt;
  logic       r_busy,      w_busy_nxt;
  logic       w_tx_req;

  logic w_sclk, w_sda, w_sclk_rise, w_sclk_fall, w_start, w_stop;

  // Preset to 1 so an idle (released) bus produces no spurious edges out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '1;
      r_sda_sync  <= '1;
      r_sclk_hist <= 1'b1;
      r_sda_hist  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
      r_sda_hist  <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_sda       = r_sda_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk & r_sclk_hist;
  assign w_start     = w_sclk & r_sda_hist & ~w_sda;
  assign w_stop      = w_sclk & ~r_sda_hist & w_sda;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= 8'h00;
      r_cnt       <= 3'd0;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_acked     <= 1'b0;
      r_sda_out   <= 1'b1;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_rw        <= w_rw_nxt;
      r_acked     <= w_acked_nxt;
      r_sda_out   <= w_sda_out_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_byte_done_nxt = r_byte_done;
    w_rw_nxt        = r_rw;
    w_acked_nxt     = r_acked;
    w_sda_out_nxt   = r_sda_out;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    w_tx_req        = 1'b0;

    // Bus conditions pre-empt any bit edge seen in the same cycle; a partial byte is dropped.
    if (w_start) begin
      w_state_nxt     = ADDR;
      w_cnt_nxt       = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_sda_out_nxt   = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = IDLE;
      w_cnt_nxt       = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_sda_out_nxt   = 1'b1;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        ADDR, WRITE: begin
          if (w_sclk_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            if (r_cnt == 3'd7) w_byte_done_nxt = 1'b1;
            else               w_cnt_nxt       = r_cnt + 3'd1;
          end else if (w_sclk_fall && r_byte_done) begin
            w_cnt_nxt       = 3'd0;
            w_byte_done_nxt = 1'b0;
            if (r_state == ADDR) begin
              if (r_shift[7:1] == TARGET_ADDR) begin
                w_rw_nxt      = r_shift[0];
                w_sda_out_nxt = 1'b0;
                w_busy_nxt    = 1'b1;
                w_state_nxt   = ADDR_ACK;
              end else begin
                w_sda_out_nxt = 1'b1;
                w_state_nxt   = IGNORE;
              end
            end else begin
              w_rx_data_nxt  = r_shift;
              w_rx_valid_nxt = 1'b1;
              w_sda_out_nxt  = 1'b0;
              w_state_nxt    = WRITE_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (w_sclk_fall) begin
            w_cnt_nxt = 3'd0;
            if (r_rw) begin
              w_tx_req      = 1'b1;
              w_shift_nxt   = bus.tx_data;
              w_sda_out_nxt = bus.tx_data[7];
              w_state_nxt   = READ;
            end else begin
              w_sda_out_nxt = 1'b1;
              w_state_nxt   = WRITE;
            end
          end
        end
        WRITE_ACK: begin
          if (w_sclk_fall) begin
            w_sda_out_nxt = 1'b1;
            w_cnt_nxt     = 3'd0;
            w_state_nxt   = WRITE;
          end
        end
        READ: begin
          if (w_sclk_rise) begin
            if (r_cnt == 3'd7) w_byte_done_nxt = 1'b1;
            else               w_cnt_nxt       = r_cnt + 3'd1;
          end else if (w_sclk_fall) begin
            if (r_byte_done) begin
              w_sda_out_nxt   = 1'b1;
              w_byte_done_nxt = 1'b0;
              w_cnt_nxt       = 3'd0;
              w_acked_nxt     = 1'b0;
              w_state_nxt     = READ_ACK;
            end else begin
              w_sda_out_nxt = r_shift[6];
              w_shift_nxt   = {r_shift[6:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          if (w_sclk_rise) begin
            if (w_sda) w_state_nxt = IGNORE;
            else       w_acked_nxt = 1'b1;
          end else if (w_sclk_fall && r_acked) begin
            w_acked_nxt   = 1'b0;
            w_tx_req      = 1'b1;
            w_shift_nxt   = bus.tx_data;
            w_sda_out_nxt = bus.tx_data[7];
            w_cnt_nxt     = 3'd0;
            w_state_nxt   = READ;
          end
        end
        default: begin
          w_sda_out_nxt = 1'b1;
        end
      endcase
    end
  end

  assign bus.sda_out  = r_sda_out;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_req   = w_tx_req;
  assign bus.busy     = r_busy;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench: bit-banged I2C master against i2c_target
module tb_i2c_target;
  localparam int PH = 8;

  logic       clk = 1'b0;
  logic       r_rst = 1'b0;
  logic       m_sclk = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] m_tx = 8'h00;

  int n_pass = 0;
  int n_total = 0;
  int rx_cnt = 0, tx_cnt = 0, low_cnt = 0, viol_cnt = 0;
  logic prev_sda = 1'b1;

  i2c_target_if bus ();

  // Open-drain bus: either side can pull the line low.
  assign bus.sclk    = m_sclk;
  assign bus.sda_in  = m_sda & bus.sda_out;
  assign bus.tx_data = m_tx;

  i2c_target #(.TARGET_ADDR(7'h5A), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (r_rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.rx_valid) rx_cnt = rx_cnt + 1;
    if (bus.tx_req) tx_cnt = tx_cnt + 1;
    if (!bus.sda_out) low_cnt = low_cnt + 1;
    if (bus.sda_out !== prev_sda && m_sclk) viol_cnt = viol_cnt + 1;
    prev_sda = bus.sda_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;
    tick(PH);
    m_sclk = 1'b1;
    tick(PH);
    s = bus.sda_in;
    m_sclk = 1'b0;
    tick(PH);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(PH);
    m_sclk = 1'b1;
    tick(PH);
    m_sda = 1'b0;
    tick(PH);
    m_sclk = 1'b0;
    tick(PH);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(PH);
    m_sclk = 1'b1;
    tick(PH);
    m_sda = 1'b1;
    tick(PH);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_rx;
    logic [2:0] exp_state;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rx0, tx0, low0;

    vecs[0] = '{8'hB4, 8'hC3, 1'b0, 1'b0, 1, 3'd3, 1'b1};
    vecs[1] = '{8'h56, 8'hFF, 1'b1, 1'b1, 0, 3'd7, 1'b0};
    vecs[2] = '{8'hB4, 8'h00, 1'b0, 1'b0, 1, 3'd3, 1'b1};
    vecs[3] = '{8'hB6, 8'h5A, 1'b1, 1'b1, 0, 3'd7, 1'b0};
    vecs[4] = '{8'hB4, 8'h7E, 1'b0, 1'b0, 1, 3'd3, 1'b1};

    tick(3);
    check("rst_sda_out",  bus.sda_out,  1);
    check("rst_rx_data",  bus.rx_data,  8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_req",   bus.tx_req,   0);
    check("rst_busy",     bus.busy,     0);
    check("rst_state",    bus.state,    0);
    r_rst = 1'b1;
    tick(PH);

    for (int v = 0; v < 5; v++) begin
      rx0  = rx_cnt;
      low0 = low_cnt;
      i2c_start();
      write_byte(vecs[v].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_aack);
      write_byte(vecs[v].data, ack);
      check($sformatf("v%0d_data_ack", v), ack, vecs[v].exp_dack);
      check($sformatf("v%0d_state", v), bus.state, vecs[v].exp_state);
      check($sformatf("v%0d_busy", v), bus.busy, vecs[v].exp_busy);
      i2c_stop();
      tick(PH);
      check($sformatf("v%0d_rx_count", v), rx_cnt - rx0, vecs[v].exp_rx);
      if (vecs[v].exp_rx != 0) check($sformatf("v%0d_rx_data", v), bus.rx_data, vecs[v].data);
      check($sformatf("v%0d_sda_driven", v), (low_cnt != low0), !vecs[v].exp_aack);
      check($sformatf("v%0d_state_end", v), bus.state, 0);
      check($sformatf("v%0d_busy_end", v), bus.busy, 0);
    end

    // Two-byte read: ACK first byte, NACK second.
    tx0  = tx_cnt;
    m_tx = 8'hA5;
    i2c_start();
    write_byte(8'hB5, ack);
    check("rd_addr_ack", ack, 0);
    m_tx = 8'h3C;
    read_byte(1'b0, rd);
    check("rd_byte0", rd, 8'hA5);
    read_byte(1'b1, rd);
    check("rd_byte1", rd, 8'h3C);
    check("rd_state_nack", bus.state, 7);
    check("rd_tx_req_count", tx_cnt - tx0, 2);
    i2c_stop();
    tick(PH);
    check("rd_state_end", bus.state, 0);

    // Write then repeated START into a read, no STOP in between.
    rx0  = rx_cnt;
    m_tx = 8'h80;
    i2c_start();
    write_byte(8'hB4, ack);
    write_byte(8'h11, ack);
    check("rs_data_ack", ack, 0);
    i2c_start();
    check("rs_busy_held", bus.busy, 1);
    write_byte(8'hB5, ack);
    check("rs_addr_ack", ack, 0);
    read_byte(1'b1, rd);
    check("rs_read", rd, 8'h80);
    check("rs_rx_data", bus.rx_data, 8'h11);
    check("rs_rx_count", rx_cnt - rx0, 1);
    i2c_stop();
    tick(PH);

    // STOP after half a data byte.
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hB4, ack);
    for (int i = 0; i < 4; i++) clock_bit(i[0], ack);
    i2c_stop();
    tick(PH);
    check("ab_rx_count", rx_cnt - rx0, 0);
    check("ab_state", bus.state, 0);
    check("ab_sda_out", bus.sda_out, 1);

    // Asynchronous reset while the target is driving a read bit low.
    m_tx = 8'h00;
    i2c_start();
    write_byte(8'hB5, ack);
    clock_bit(1'b1, ack);
    clock_bit(1'b1, ack);
    check("rr_sda_low_pre", bus.sda_out, 0);
    #1 r_rst = 1'b0;
    #1;
    check("rr_sda_async", bus.sda_out, 1);
    check("rr_state_async", bus.state, 0);
    tick(3);
    r_rst = 1'b1;
    low0 = low_cnt;
    write_byte(8'hB4, ack);
    check("rr_no_ack", ack, 1);
    check("rr_state_idle", bus.state, 0);
    check("rr_never_driven", (low_cnt != low0), 0);

    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hB4, ack);
    write_byte(8'h5E, ack);
    i2c_stop();
    tick(PH);
    check("rr_recover_count", rx_cnt - rx0, 1);
    check("rr_recover_data", bus.rx_data, 8'h5E);
    check("sda_change_sclk_high", viol_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
